chacha20_keystream_xor: RTL and testbench

Downstream consumer of the ChaCha20 core. It requests 512-bit keystream blocks from the core, buffers one block, and XORs it word-by-word onto a 32-bit plaintext stream (card data) with valid/ready handshakes on both sides. It also supplies the block counter the core loads into state word 12, and it flags a core that never answers.

---
 rtl/chacha_pkg.sv | 22 ++
 rtl/chacha20_keystream_xor.sv | 143 ++++++++++++++
 tb/tb_chacha20_keystream_xor.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/chacha_pkg.sv
// Shared constants, FSM state type and keystream word selection for the
// ChaCha20 keystream XOR stage.
package chacha_pkg;

    localparam int WORD_W   = 32;
    localparam int BLOCK_W  = 512;
    localparam int KS_WORDS = 16;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        REQ    = 2'd1,
        WAIT   = 2'd2,
        STREAM = 2'd3
    } ks_state_t;

    // Word 0 sits in the most significant 32 bits of the block.
    function automatic logic [WORD_W-1:0] ks_word(input logic [BLOCK_W-1:0] blk,
                                                  input logic [3:0]         idx);
        return blk[BLOCK_W-1-WORD_W*int'(idx) -: WORD_W];
    endfunction

endpackage

// File: rtl/chacha20_keystream_xor.sv
// Fetches 512-bit keystream blocks from the ChaCha20 core, buffers one block
// and XORs it word-by-word onto the plaintext stream.
module chacha20_keystream_xor
    import chacha_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic         in_last,
    output logic         ks_req,
    input  logic         ks_valid,
    input  logic [511:0] ks_block,
    output logic [31:0]  blk_ctr,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_data,
    output logic         out_last,
    output logic         err_timeout,
    output logic         busy,
    output logic [1:0]   state_dbg
);

    localparam int TIMER_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    ks_state_t           state_q, state_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic [3:0]          idx_q, idx_d;
    logic [BLOCK_W-1:0]  buf_q, buf_d;
    logic [WORD_W-1:0]   ctr_q, ctr_d;
    logic                err_q, err_d;
    logic                ov_q, ov_d;
    logic [WORD_W-1:0]   od_q, od_d;
    logic                ol_q, ol_d;

    logic                in_ready_c;
    logic                xfer;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= EMPTY;
            timer_q <= '0;
            idx_q   <= '0;
            buf_q   <= '0;
            ctr_q   <= '0;
            err_q   <= 1'b0;
            ov_q    <= 1'b0;
            od_q    <= '0;
            ol_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            ctr_q   <= ctr_d;
            err_q   <= err_d;
            ov_q    <= ov_d;
            od_q    <= od_d;
            ol_q    <= ol_d;
        end
    end

    // Both ports use valid/ready: a word moves on a rising edge where valid
    // and ready are both high; valid never waits on ready, and a held word
    // keeps its data/last stable until taken.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        idx_d      = idx_q;
        buf_d      = buf_q;
        ctr_d      = ctr_q;
        err_d      = err_q;
        ov_d       = ov_q;
        od_d       = od_q;
        ol_d       = ol_q;
        in_ready_c = (state_q == STREAM) && (!ov_q || out_ready);
        xfer       = in_valid && in_ready_c;

        if (out_ready) begin
            ov_d = 1'b0;
        end

        case (state_q)
            EMPTY: begin
                if (in_valid) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                timer_d = timer_q + 1'b1;
                // A block arriving in the timeout cycle still counts.
                if (ks_valid) begin
                    buf_d   = ks_block;
                    idx_d   = '0;
                    ctr_d   = ctr_q + 1'b1;
                    state_d = STREAM;
                end else if (timer_d == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = EMPTY;
                end
            end
            STREAM: begin
                if (xfer) begin
                    od_d = in_data ^ ks_word(buf_q, idx_q);
                    ol_d = in_last;
                    ov_d = 1'b1;
                    if (in_last) begin
                        idx_d   = '0;
                        ctr_d   = '0;
                        buf_d   = '0;
                        state_d = EMPTY;
                    end else if (idx_q == 4'(KS_WORDS - 1)) begin
                        idx_d   = '0;
                        state_d = EMPTY;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    assign in_ready    = in_ready_c;
    assign ks_req      = (state_q == REQ);
    assign blk_ctr     = ctr_q;
    assign out_valid   = ov_q;
    assign out_data    = od_q;
    assign out_last    = ol_q;
    assign err_timeout = err_q;
    assign busy        = (state_q != EMPTY) || ov_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_chacha20_keystream_xor.sv
// Directed bench for chacha20_keystream_xor: a core model answers ks_req,
// a driver issues plaintext, and a monitor checks ciphertext against exp_q.
module tb_chacha20_keystream_xor;

    logic         clk;
    logic         resetn;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         in_last;
    logic         ks_req;
    logic         ks_valid;
    logic [511:0] ks_block;
    logic [31:0]  blk_ctr;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic         out_last;
    logic         err_timeout;
    logic         busy;
    logic [1:0]   state_dbg;

    int           total = 0;
    int           bad   = 0;
    logic [32:0]  exp_q[$];
    logic [31:0]  req_log[$];
    logic [511:0] blk_a;
    logic [511:0] blk_b;
    bit           core_en  = 1'b1;
    int           core_lat = 22;

    chacha20_keystream_xor #(.TIMEOUT_CYCLES(64)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .ks_req      (ks_req),
        .ks_valid    (ks_valid),
        .ks_block    (ks_block),
        .blk_ctr     (blk_ctr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .err_timeout (err_timeout),
        .busy        (busy),
        .state_dbg   (state_dbg)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Core model: block A for counter 0, block B for counter 1.
    initial begin
        ks_valid = 1'b0;
        ks_block = '0;
        forever begin
            @(negedge clk);
            if (resetn && ks_req) begin
                logic [31:0] ctr;
                ctr = blk_ctr;
                req_log.push_back(ctr);
                if (core_en) begin
                    repeat (core_lat) @(negedge clk);
                    check("ctr_stable", 64'(blk_ctr), 64'(ctr));
                    ks_block = (ctr == 32'd1) ? blk_b : blk_a;
                    ks_valid = 1'b1;
                    @(negedge clk);
                    ks_valid = 1'b0;
                end
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (resetn && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 64'({out_last, out_data}), 64'h1_DEAD_BEEF);
                end else begin
                    logic [32:0] e;
                    e = exp_q.pop_front();
                    check("out_word", 64'({out_last, out_data}), 64'(e));
                end
            end
        end
    end

    // Driver: called just after a rising edge, returns just after the accepting edge.
    task automatic send_word(input logic [31:0] d, input logic last, input logic [31:0] kw);
        int  n;
        bit  ok;
        n  = 0;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        exp_q.push_back({last, d ^ kw});
        while (n < 300 && !ok) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            n++;
        end
        check("in_handshake", 64'(ok), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic stall(input logic [31:0] held);
        out_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("stall_hold", 64'({out_valid, out_last, in_ready, out_data}),
                  64'({1'b1, 1'b0, 1'b0, held}));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            blk_a[511-32*i -: 32] = 32'(i);
            blk_b[511-32*i -: 32] = 32'hC0DE0000 + 32'(i);
        end
        resetn    = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h12345678;
        in_last   = 1'b0;
        out_ready = 1'b1;

        // Reset with in_valid high: everything quiet
        repeat (3) begin
            @(negedge clk);
            check("reset_outputs",
                  64'({in_ready, ks_req, out_valid, out_last, err_timeout, busy, state_dbg}), 64'd0);
            check("reset_data", 64'({blk_ctr, out_data}), 64'd0);
        end
        @(posedge clk);
        #1;
        resetn   = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // 16-word message on block A
        for (int i = 0; i < 16; i++) begin
            send_word(32'hFFFF0000 + 32'(i), (i == 15), 32'(i));
            if (i == 0) check("ctr_after_capture", 64'(blk_ctr), 64'd1);
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("msg1_ctr_cleared", 64'(blk_ctr), 64'd0);
        check("msg1_state_empty", 64'(state_dbg), 64'd0);
        check("msg1_req_count", 64'(req_log.size()), 64'd1);
        if (req_log.size() > 0) check("msg1_req_ctr", 64'(req_log[0]), 64'd0);
        repeat (3) @(negedge clk);
        check("msg1_idle", 64'({busy, in_ready}), 64'd0);
        req_log.delete();
        @(posedge clk);
        #1;

        // 20-word message spanning block A and block B
        for (int j = 0; j < 20; j++) begin
            send_word(32'h12340000 + 32'(j), (j == 19),
                      (j < 16) ? 32'(j) : (32'hC0DE0000 + 32'(j - 16)));
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("msg2_req_count", 64'(req_log.size()), 64'd2);
        if (req_log.size() == 2) begin
            check("msg2_req0_ctr", 64'(req_log[0]), 64'd0);
            check("msg2_req1_ctr", 64'(req_log[1]), 64'd1);
        end
        check("msg2_ctr_cleared", 64'(blk_ctr), 64'd0);
        req_log.delete();
        @(posedge clk);
        #1;

        // Backpressure: output stalled for 5 cycles while word 8 waits
        for (int i = 0; i < 16; i++) begin
            if (i == 8) begin
                fork
                    send_word(32'h5A5A0000 + 32'(i), 1'b0, 32'(i));
                    stall(32'h5A5A0000);
                join
            end else begin
                send_word(32'h5A5A0000 + 32'(i), (i == 15), 32'(i));
            end
        end
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("bp_drained", 64'(exp_q.size()), 64'd0);
        req_log.delete();
        @(posedge clk);
        #1;

        // Timeout: core never answers
        core_en  = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'hAAAA0000;
        in_last  = 1'b1;
        begin
            int  n;
            bit  seen;
            n    = 0;
            seen = 1'b0;
            while (n < 10 && !seen) begin
                @(negedge clk);
                if (ks_req) seen = 1'b1;
                n++;
            end
            check("to_req_seen", 64'(seen), 64'd1);
            n    = 0;
            seen = 1'b0;
            while (n < 100 && !seen) begin
                @(negedge clk);
                n++;
                if (err_timeout) seen = 1'b1;
            end
            check("to_err_cycles", 64'(n), 64'd64);
            check("to_state", 64'({state_dbg, in_ready}), 64'd0);
            @(negedge clk);
            check("to_retry_req", 64'(ks_req), 64'd1);
            check("to_err_sticky", 64'(err_timeout), 64'd1);
        end
        in_valid = 1'b0;
        resetn   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn  = 1'b1;
        core_en = 1'b1;
        @(negedge clk);
        check("to_err_reset", 64'(err_timeout), 64'd0);
        req_log.delete();
        @(posedge clk);
        #1;

        // Reset mid-stream at word 7
        for (int i = 0; i < 7; i++) begin
            send_word(32'h0BAD0000 + 32'(i), 1'b0, 32'(i));
        end
        in_data = 32'h0BAD0007;
        resetn  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        resetn   = 1'b1;
        check("rst_inflight", 64'(exp_q.size()), 64'd1);
        exp_q.delete();
        @(negedge clk);
        check("rst_state", 64'({out_valid, err_timeout, busy, state_dbg}), 64'd0);
        check("rst_ctr", 64'(blk_ctr), 64'd0);
        req_log.delete();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            send_word(32'h0BAD0100 + 32'(i), (i == 3), 32'(i));
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("rst_new_req", 64'(req_log.size()), 64'd1);
        if (req_log.size() > 0) check("rst_new_req_ctr", 64'(req_log[0]), 64'd0);
        req_log.delete();
        @(posedge clk);
        #1;

        // ks_valid in the timeout cycle wins
        core_lat = 63;
        send_word(32'h77770000, 1'b0, 32'd0);
        send_word(32'h77770001, 1'b1, 32'd1);
        in_valid = 1'b0;
        @(negedge clk);
        check("late_no_err", 64'(err_timeout), 64'd0);

        repeat (5) @(negedge clk);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        check("final_idle", 64'({busy, out_valid}), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
